adder_share_ctrl: RTL and testbench

//  Shares one WIDTH-bit adder (CSA_ADDER3 instance) among NREQ requesters.

---
 rtl/adder_share_pkg.sv | 18 +
 rtl/CSA_ADDER3.sv | 14 +
 rtl/adder_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/adder_share_ctrl.sv | 157 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing controller slice.
package adder_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_RESP
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_NREQ  = 4;

  // Requester id width; a single requester still gets a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/CSA_ADDER3.sv
// Shared WIDTH-bit adder: S/Cout = A + B + Cin.
module CSA_ADDER3 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one CSA_ADDER3 among NREQ requesters with round-robin grant.
// Define ADDER_OVF_EN to add the registered signed-overflow output rsp_ovf.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NREQ  = DEF_NREQ,
  localparam int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
`ifdef ADDER_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
`ifdef ADDER_OVF_EN
  logic             rsp_ovf_q, rsp_ovf_d;
`endif

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [WIDTH-1:0] sel_a, sel_b, add_s;
  logic             sel_cin, add_cout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // The adder only ever sees captured operands, never live request inputs.
  CSA_ADDER3 #(.WIDTH(WIDTH)) u_adder (
    .A    (op_a_q),
    .B    (op_b_q),
    .Cin  (op_cin_q),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    op_id_d    = op_id_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
`ifdef ADDER_OVF_EN
    rsp_ovf_d  = rsp_ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_cin_d = sel_cin;
          op_id_d  = gnt_id;
          rr_ptr_d = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_sum_d  = add_s;
        rsp_cout_d = add_cout;
        rsp_id_d   = op_id_q;
`ifdef ADDER_OVF_EN
        rsp_ovf_d  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                     (add_s[WIDTH-1] != op_a_q[WIDTH-1]);
`endif
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      op_id_q    <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
`ifdef ADDER_OVF_EN
      rsp_ovf_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      op_id_q    <= op_id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
`ifdef ADDER_OVF_EN
      rsp_ovf_q  <= rsp_ovf_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ADDER_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl (WIDTH=32, NREQ=4); rsp_ovf checks need ADDER_OVF_EN.
module tb_adder_share_ctrl;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_cin;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
`ifdef ADDER_OVF_EN
  logic           rsp_ovf;
`endif
  logic           busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  adder_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADDER_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next active edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_cin[idx]      = cin;
  endtask

  // One isolated transaction; starts and ends just after an active edge in IDLE.
  task automatic run_single(input int unsigned idx, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin,
                            input logic [W-1:0] es, input logic ec);
    set_req(idx, a, b, cin);
    req_valid[idx] = 1'b1;
    rsp_ready      = 1'b1;
    @(negedge clk);
    check("grant", 64'(req_ready), 64'(1) << idx);
    check("idle_busy", 64'(busy), 64'd0);
    tick();
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check("calc_valid", 64'(rsp_valid), 64'd0);
    check("calc_ready", 64'(req_ready), 64'd0);
    check("calc_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("resp_valid", 64'(rsp_valid), 64'd1);
    check("resp_id", 64'(rsp_id), 64'(idx));
    check("resp_sum", 64'(rsp_sum), 64'(es));
    check("resp_cout", 64'(rsp_cout), 64'(ec));
    tick();
  endtask

  initial begin
    logic [W-1:0] t3_sum [N];
    t3_sum = '{32'h0000_0001, 32'h0000_0013, 32'h0000_0023, 32'h0000_0035};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_sum", 64'(rsp_sum), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_cout", 64'(rsp_cout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // 1, 2: wrap-around sums with carry out
    run_single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    run_single(2, 32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 32'h0000_0003, 1'b1);

    // 3: all requesters pending from reset, served 0..3 three cycles apart
    rst = 1'b1; #2; rst = 1'b0;
    for (int unsigned k = 0; k < N; k++) set_req(k, W'(k*16 + 1), W'(k), k[0]);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(1) << k);
      tick();
      req_valid[k] = 1'b0;
      @(negedge clk);
      check("rr_calc_valid", 64'(rsp_valid), 64'd0);
      tick();
      @(negedge clk);
      check("rr_valid", 64'(rsp_valid), 64'd1);
      check("rr_id", 64'(rsp_id), 64'(k));
      check("rr_sum", 64'(rsp_sum), 64'(t3_sum[k]));
      tick();
    end

    // 4: consumer stalls in RESP; no grant and stable response while stalled
    set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    req_valid = '1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_sum", 64'(rsp_sum), 64'h2345_6789);
      check("stall_id", 64'(rsp_id), 64'd1);
      check("stall_ready", 64'(req_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_done_busy", 64'(busy), 64'd0);
    check("stall_done_valid", 64'(rsp_valid), 64'd0);
    tick();

    // 5: reset while in CALC discards the op and rewinds the pointer
    set_req(2, 32'h0000_00AA, 32'h0000_0055, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    check("abort_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    rst = 1'b1; #2; rst = 1'b0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_valid", 64'(rsp_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      tick();
    end
    check("abort_sum", 64'(rsp_sum), 64'd0);
    req_valid = '1;
    @(negedge clk);
    check("abort_ptr", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    rst = 1'b1; #2; rst = 1'b0;
    tick();

`ifdef ADDER_OVF_EN
    // 6: signed overflow flag
    run_single(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    check("ovf_set", 64'(rsp_ovf), 64'd1);
    run_single(0, 32'h0000_0007, 32'h0000_000A, 1'b0, 32'h0000_0011, 1'b0);
    check("ovf_clr", 64'(rsp_ovf), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
